// File: rtl/fault_enc_pkg.sv
// Shared types for the flip/patch fault-aware weight encoder.
// Holds the decision encoding and the counter-width helper.
package fault_enc_pkg;

    typedef enum logic [1:0] {
        KEEP,
        FLIP,
        PATCH,
        BEST
    } dec_e;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/popcount.sv
// Population count of an N-bit vector.
// Pure combinational adder chain; result is cnt_w(N) bits wide.
module popcount
    import fault_enc_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]          vec_i,
    output logic [cnt_w(N)-1:0]   cnt_o
);

    localparam int W = cnt_w(N);

    // Accumulate one bit at a time.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/flip_patch_encoder.sv
// Two-stage encoder choosing keep / flip / patch for a word
// written into a row with known stuck-at cells.
module flip_patch_encoder
    import fault_enc_pkg::*;
#(
    parameter int N           = 16,
    parameter int PATCH_DEPTH = 8,
    parameter int MAX_ERR     = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N-1:0]                in_data,
    input  logic [N-1:0]                in_sa_mask,
    input  logic [N-1:0]                in_sa_val,
    input  logic                        clear_patches,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                a_original,
    output logic [N-1:0]                a_flipped,
    output logic [N-1:0]                a_patched,
    output logic                        f,
    output logic                        p,
    output logic [cnt_w(PATCH_DEPTH)-1:0] patch_count,
    output logic                        patch_full,
    output logic                        overflow
);

    localparam int CW = cnt_w(N);
    localparam int PW = cnt_w(PATCH_DEPTH);
    localparam logic [CW-1:0] MAX_E   = CW'(MAX_ERR);
    localparam logic [PW-1:0] DEPTH_V = PW'(PATCH_DEPTH);

    logic [N-1:0]  diff_o, diff_f;
    logic [CW-1:0] mism_o, mism_f;

    logic          s1_valid_q, s1_valid_d;
    logic [N-1:0]  s1_data_q, s1_data_d;
    logic [CW-1:0] s1_mo_q, s1_mo_d;
    logic [CW-1:0] s1_mf_q, s1_mf_d;

    logic          s2_valid_q, s2_valid_d;
    logic [N-1:0]  s2_data_q, s2_data_d;
    logic [CW-1:0] s2_mo_q, s2_mo_d;
    logic [CW-1:0] s2_mf_q, s2_mf_d;

    logic [PW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic          s1_adv, accept, out_hs, full;
    dec_e          dec;

    assign diff_o = (in_data ^ in_sa_val) & in_sa_mask;
    assign diff_f = (~in_data ^ in_sa_val) & in_sa_mask;

    popcount #(.N(N)) u_pc_orig (
        .vec_i (diff_o),
        .cnt_o (mism_o)
    );

    popcount #(.N(N)) u_pc_flip (
        .vec_i (diff_f),
        .cnt_o (mism_f)
    );

    // Handshake: ready is gated by reset so nothing enters while held.
    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = rst_n && (!s1_valid_q || s1_adv);
    assign accept   = in_valid && in_ready;
    assign out_hs   = s2_valid_q && out_ready;
    assign full     = (cnt_q == DEPTH_V);

    // Decision uses the live patch count so consecutive PATCH words
    // each see the slots consumed by the ones ahead of them.
    always_comb begin
        dec = BEST;
        if (s2_mo_q <= MAX_E) begin
            dec = KEEP;
        end else if (s2_mf_q <= MAX_E) begin
            dec = FLIP;
        end else if (!full) begin
            dec = PATCH;
        end
    end

    // Pipeline and patch-slot bookkeeping next state.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mo_d    = s1_mo_q;
        s1_mf_d    = s1_mf_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_mo_d    = s2_mo_q;
        s2_mf_d    = s2_mf_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;

        if (in_ready) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_data_d = in_data;
                s1_mo_d   = mism_o;
                s1_mf_d   = mism_f;
            end
        end

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
                s2_mo_d   = s1_mo_q;
                s2_mf_d   = s1_mf_q;
            end
        end

        if (clear_patches) begin
            cnt_d = (out_hs && dec == PATCH) ? PW'(1) : '0;
            ovf_d = 1'b0;
        end else begin
            if (out_hs && dec == PATCH && cnt_q != DEPTH_V) begin
                cnt_d = cnt_q + PW'(1);
            end
            if (out_hs && dec == BEST) begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mo_q    <= '0;
            s1_mf_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mo_q    <= '0;
            s2_mf_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mo_q    <= s1_mo_d;
            s1_mf_q    <= s1_mf_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_mo_q    <= s2_mo_d;
            s2_mf_q    <= s2_mf_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Outputs are zeroed whenever stage 2 holds nothing.
    always_comb begin
        out_valid   = s2_valid_q;
        a_original  = s2_valid_q ? s2_data_q : '0;
        a_flipped   = s2_valid_q ? ~s2_data_q : '0;
        a_patched   = s2_valid_q ? s2_data_q : '0;
        f           = s2_valid_q &&
                      (dec == FLIP || (dec == BEST && s2_mf_q < s2_mo_q));
        p           = s2_valid_q && (dec == PATCH);
        patch_count = cnt_q;
        patch_full  = full;
        overflow    = ovf_q || (s2_valid_q && dec == BEST);
    end

endmodule
